// File: rtl/prog_loader_pkg.sv
// Shared state encodings and sizing constants for the boot-time program loader.
// Optional checksum stage is enabled with the PROG_LOADER_CHECKSUM_EN macro.
package prog_loader_pkg;

    localparam int MAX_WORDS_DEF  = 64;
    localparam int BYTES_PER_WORD = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_HDR   = 3'd1;
    localparam state_t ST_DATA  = 3'd2;
    localparam state_t ST_WRITE = 3'd3;
    localparam state_t ST_CHK   = 3'd4;
    localparam state_t ST_DONE  = 3'd5;
    localparam state_t ST_ERR   = 3'd6;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and memory write port of the program loader.
// A byte moves on a clk edge where rx_valid && rx_ready; the source holds the byte until then.
interface prog_loader_if;

    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wd;

    modport master (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output mem_we,
        output mem_adr,
        output mem_wd
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  mem_we,
        input  mem_adr,
        input  mem_wd
    );

endinterface

// File: rtl/prog_loader_byte_packer.sv
// Packs an MSB-first byte stream into 32-bit words; word_full flags the 4th byte
// of a word in the cycle it is being shifted in.
module prog_loader_byte_packer
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clr) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (shift_en) begin
            cnt_d  = cnt_q + 2'd1;
            word_d = {word_q[23:0], byte_in};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word      = word_q;
    assign word_full = shift_en && !clr && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// Boot loader: header byte N, then 4N bytes packed into words written from address 0.
// Holds the core in reset until a good image is in memory. Checksum stage: PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int MAX_WORDS = MAX_WORDS_DEF,
    parameter int CNT_W     = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    prog_loader_if.master     bus,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  word_count,
    output state_t            state_dbg
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        adr_q, adr_d;
    logic [31:0]        wd_q, wd_d;
    logic               cpu_reset_q, cpu_reset_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               rx_ready;
    logic               accept;
    logic               start;
    logic               hdr_ok;
    logic               last_word;
    logic               shift_en;
    logic               word_full;
    logic [31:0]        packed_word;
    logic [31:0]        cur_adr;

    assign rx_ready  = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CHK);
    assign accept    = bus.rx_valid && rx_ready;
    assign start     = load_start &&
                       ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
    assign hdr_ok    = (bus.rx_data != 8'd0) && ({24'd0, bus.rx_data} <= 32'(MAX_WORDS));
    assign last_word = (idx_q == (n_q - CNT_W'(1)));
    assign shift_en  = (state_q == ST_DATA) && bus.rx_valid;
    assign cur_adr   = 32'({idx_q, 2'b00});

    prog_loader_byte_packer u_byte_packer (
        .clk       (clk),
        .reset     (reset),
        .clr       (state_q == ST_HDR),
        .shift_en  (shift_en),
        .byte_in   (bus.rx_data),
        .word      (packed_word),
        .word_full (word_full)
    );

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    // Sum is zero on entry to HDR, so the header byte is folded in like any data byte.
    always_comb begin
        sum_d = sum_q;
        if (start) begin
            sum_d = '0;
        end else if (accept) begin
            sum_d = sum_q + bus.rx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        adr_d       = adr_q;
        wd_d        = wd_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d     = ST_HDR;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    cnt_d       = '0;
                    cpu_reset_d = 1'b1;
                end
            end
            ST_HDR: begin
                if (accept) begin
                    if (hdr_ok) begin
                        n_d     = CNT_W'(bus.rx_data);
                        idx_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end
                end
            end
            ST_DATA: begin
                if (word_full) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                cnt_d = cnt_q + CNT_W'(1);
                adr_d = cur_adr;
                wd_d  = packed_word;
                if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d     = ST_CHK;
`else
                    state_d     = ST_DONE;
                    done_d      = 1'b1;
                    cpu_reset_d = 1'b0;
`endif
                end else begin
                    idx_d   = idx_q + CNT_W'(1);
                    state_d = ST_DATA;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    if (bus.rx_data == sum_q) begin
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            n_q         <= '0;
            cnt_q       <= '0;
            adr_q       <= '0;
            wd_q        <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            adr_q       <= adr_d;
            wd_q        <= wd_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Address/data show the live word during WRITE and hold the last write otherwise.
    assign bus.rx_ready = rx_ready;
    assign bus.mem_we   = (state_q == ST_WRITE);
    assign bus.mem_adr  = (state_q == ST_WRITE) ? cur_adr : adr_q;
    assign bus.mem_wd   = (state_q == ST_WRITE) ? packed_word : wd_q;

    assign busy       = (state_q == ST_HDR) || (state_q == ST_DATA) ||
                        (state_q == ST_WRITE) || (state_q == ST_CHK);
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign err        = err_q;
    assign word_count = cnt_q;
    assign state_dbg  = state_q;

endmodule
